ds1302_slave_model: RTL
=======================

// Module: ds1302_slave_model
// PURPOSE
//  Synthesizable DS1302 responder: the device end of the 3-wire CE/SCLK/IO link
//  driven by our ds1302 controller. It oversamples the bus on sysclk and decodes
//  command bytes. It serves clock-register reads and writes, with write-protect.
//  It keeps BCD time from a 1 Hz tick, so the controller can be exercised on-chip
//  without a physical RTC.
// PARAMETERS
//  SYNC_STAGES  2     flops per synchronizer on ce/sclk/io input (>=2)
//  PWR_ON_CH    1     reset value of clock-halt bit (sec[7]); 1 = halted like real chip
// PORTS
//  sysclk       in   1  system clock; must be >= 8x SCLK frequency
//  rst          in   1  asynchronous, active-high reset
//  ds1302_ce    in   1  chip enable from master
//  ds1302_sclk  in   1  serial clock from master
//  ds1302_io    inout 1 serial data; driven only during read-data phase, else 'z'
//  tick_1hz     in   1  one-sysclk pulse per second; advances time when CH=0
//  cur_second   out  8  BCD seconds register (bit7 = CH)
//  cur_minute   out  8  BCD minutes register
//  cur_hour     out  8  BCD hours, 24-h only (bit7 forced 0)
//  busy         out  1  high while CE (synchronized) is high
// BEHAVIOUR
//  Reset: sec=PWR_ON_CH<<7, min=hour=00, date=01, month=01, week=01, year=00,
//   wp=8'h80 (protected); io released (oe=0); busy=0; FSM=S_IDLE.
//  Sync: ce, sclk, io each pass through SYNC_STAGES flops; edges detected on sync'd
//   sclk. Rise = sample, fall = shift out.
//  Command byte: LSB first on 8 rising edges. b0=1 read/0 write; b5:1 = reg addr;
//   b6 RAM/CK; b7 must be 1.
//  Map (write/read): 80/81 sec, 82/83 min, 84/85 hour, 86/87 date, 88/89 month,
//   8A/8B week, 8C/8D year, 8E/8F wp. Only wp[7] is stored; other wp bits read 0.
//  FSM:
//   S_IDLE -> S_CMD on ce rise; bit counter cleared.
//   S_CMD -> on 8th rise, go to S_WDATA (write) or S_RDATA (read).
//     Go to S_IGNORE instead if b7=0, b6=1 (RAM), addr 31 (burst), or addr not in map.
//   S_WDATA: shift 8 data bits on rises. After the 8th, commit in one sysclk, then S_IGNORE.
//     Writes to time regs are discarded when wp[7]=1; a write to 8E is always accepted.
//   S_RDATA: the fall after the 8th command rise loads the register into the shifter.
//     oe goes to 1 and io drives bit0. Each later fall shifts out the next bit, LSB first.
//     After bit7 is driven, further falls keep driving bit7 until CE falls.
//   S_IGNORE: no drive, no writes, until ce low.
//   Any state: ce low (sync'd) -> S_IDLE next cycle, oe=0, partial write dropped.
//  Latency: io valid <= SYNC_STAGES+2 sysclk after the sclk falling edge.
//  Timekeeping: on tick with CH=0 and no commit this cycle, increment sec.
//   A tick that coincides with a commit is held pending and applied on the next
//   free cycle. At most one pending tick is held; a second tick while pending is lost.
//  BCD carries: sec 59->00 bumps min; min 59->00 bumps hour; hour 23->00 bumps date and week.
//   Week: 7 -> 1.
//   Date: last day -> 01 and bumps month. Days per month: 31/30 table; Feb = 29 if
//     year BCD %4==0 (00 counts as leap), else 28.
//   Month: 12 -> 01 and bumps year. Year: 99 -> 00.
//  Written values are stored as given, even non-BCD; rollover compares only exact end values.
//  Hour bit7 (12-h mode) is written as 0 (unsupported).
// TESTING
//  1 Reset, then read 0x81 -> io returns 8'h80 LSB first; 0x8F -> 8'h80.
//  2 Write 8E=00, 80=8'h59, 82=8'h59, 84=8'h23; one tick -> sec=00, min=00,
//    hour=00, date=02, week=02.
//  3 WP: write 8E=80, then 82=8'h12 -> min unchanged. Write 8E=00, then 82=12 -> min=12.
//  4 Leap: year=8'h24, month=02, date=8'h28, 23:59:59 -> tick -> date=29.
//    Second day rollover -> date=01, month=03. Repeat with year=8'h23 -> 02/28 rolls to 03/01.
//  5 Abort: drop CE after 4 data bits of write 80=8'h35 -> sec unchanged, io 'z'.
//    The next command decodes normally.
//  6 Tick in the same cycle as the sec commit -> written value +1 exactly one cycle later.
//    Command 0xC1 (RAM) -> io stays 'z'.

Source files
------------

// File: rtl/ds1302_slave_model.sv
// Device-side model of a DS1302 RTC: decodes CE/SCLK/IO transfers on an oversampled
// bus, serves clock-register reads/writes with write-protect and keeps BCD time.
module ds1302_slave_model #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          PWR_ON_CH   = 1'b1
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       ds1302_ce,
  input  logic       ds1302_sclk,
  inout  wire        ds1302_io,
  input  logic       tick_1hz,
  output logic [7:0] cur_second,
  output logic [7:0] cur_minute,
  output logic [7:0] cur_hour,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StCmd, StWdata, StCommit, StRdata, StIgnore} state_e;

  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] ce_sync_q, ce_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] io_sync_q, io_sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] addr_q, addr_d;
  logic       oe_q, oe_d;
  logic       pend_q, pend_d;
  logic       wp_q, wp_d;
  logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [7:0] date_q, date_d, month_q, month_d, week_q, week_d, year_q, year_d;

  logic       ce_s, sclk_s, io_s, sclk_rise, sclk_fall, commit, leap_yr;
  logic [7:0] cmd_byte, rd_val, last_day;

  // Increments the low nibble with decimal carry; non-BCD values simply count on.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return v + 8'h01;
  endfunction

  assign ce_s      = ce_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign io_s      = io_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cmd_byte  = {io_s, shift_q[7:1]};
  assign commit    = (state_q == StCommit) && ce_s;

  assign ds1302_io  = oe_q ? shift_q[0] : 1'bz;
  assign cur_second = sec_q;
  assign cur_minute = min_q;
  assign cur_hour   = hour_q;
  assign busy       = ce_s;

  // BCD year mod 4 == 0 reduces to (2*tens + ones) mod 4 == 0.
  assign leap_yr = (year_q[1:0] + {year_q[4], 1'b0}) == 2'b00;

  always_comb begin
    unique case (month_q)
      8'h04, 8'h06, 8'h09, 8'h11: last_day = 8'h30;
      8'h02:                      last_day = leap_yr ? 8'h29 : 8'h28;
      default:                    last_day = 8'h31;
    endcase
  end

  always_comb begin
    unique case (addr_q)
      3'd0:    rd_val = sec_q;
      3'd1:    rd_val = min_q;
      3'd2:    rd_val = hour_q;
      3'd3:    rd_val = date_q;
      3'd4:    rd_val = month_q;
      3'd5:    rd_val = week_q;
      3'd6:    rd_val = year_q;
      default: rd_val = {wp_q, 7'h00};
    endcase
  end

  always_comb begin
    ce_sync_d   = {ce_sync_q[SYNC_STAGES-2:0], ds1302_ce};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], ds1302_sclk};
    io_sync_d   = {io_sync_q[SYNC_STAGES-2:0], ds1302_io};
    sclk_prev_d = sclk_s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    oe_d    = oe_q;
    unique case (state_q)
      StIdle: begin
        oe_d  = 1'b0;
        cnt_d = 3'd0;
        if (ce_s) state_d = StCmd;
      end
      StCmd: begin
        if (sclk_rise) begin
          shift_d = cmd_byte;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            addr_d = cmd_byte[3:1];
            // Only clock-register single-byte accesses are served.
            if (!cmd_byte[7] || cmd_byte[6] || (cmd_byte[5:4] != 2'b00)) state_d = StIgnore;
            else if (cmd_byte[0])                                          state_d = StRdata;
            else                                                           state_d = StWdata;
          end
        end
      end
      StWdata: begin
        if (sclk_rise) begin
          shift_d = cmd_byte;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = StCommit;
        end
      end
      StCommit: state_d = StIgnore;
      StRdata: begin
        // First fall loads the register; later falls shift right, replicating bit7.
        if (sclk_fall) begin
          oe_d    = 1'b1;
          shift_d = oe_q ? {shift_q[7], shift_q[7:1]} : rd_val;
        end
      end
      StIgnore: oe_d = 1'b0;
      default:  state_d = StIdle;
    endcase
    if (!ce_s) begin
      state_d = StIdle;
      oe_d    = 1'b0;
    end
  end

  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    date_d  = date_q;
    month_d = month_q;
    week_d  = week_q;
    year_d  = year_q;
    wp_d    = wp_q;
    pend_d  = pend_q;
    if (commit) begin
      // A tick colliding with a commit is deferred by one cycle.
      pend_d = pend_q | tick_1hz;
      if (addr_q == 3'd7) begin
        wp_d = shift_q[7];
      end else if (!wp_q) begin
        unique case (addr_q)
          3'd0:    sec_d   = shift_q;
          3'd1:    min_d   = shift_q;
          3'd2:    hour_d  = {1'b0, shift_q[6:0]};
          3'd3:    date_d  = shift_q;
          3'd4:    month_d = shift_q;
          3'd5:    week_d  = shift_q;
          default: year_d  = shift_q;
        endcase
      end
    end else begin
      pend_d = 1'b0;
      if ((tick_1hz || pend_q) && !sec_q[7]) begin
        if (sec_q[6:0] == 7'h59) begin
          sec_d = {sec_q[7], 7'h00};
          if (min_q == 8'h59) begin
            min_d = 8'h00;
            if (hour_q == 8'h23) begin
              hour_d = 8'h00;
              week_d = (week_q == 8'h07) ? 8'h01 : bcd_inc(week_q);
              if (date_q == last_day) begin
                date_d = 8'h01;
                if (month_q == 8'h12) begin
                  month_d = 8'h01;
                  year_d  = (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);
                end else begin
                  month_d = bcd_inc(month_q);
                end
              end else begin
                date_d = bcd_inc(date_q);
              end
            end else begin
              hour_d = bcd_inc(hour_q);
            end
          end else begin
            min_d = bcd_inc(min_q);
          end
        end else begin
          sec_d = bcd_inc(sec_q);
        end
      end
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ce_sync_q   <= '0;
      sclk_sync_q <= '0;
      io_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      cnt_q       <= 3'd0;
      shift_q     <= 8'h00;
      addr_q      <= 3'd0;
      oe_q        <= 1'b0;
      pend_q      <= 1'b0;
      wp_q        <= 1'b1;
      sec_q       <= {PWR_ON_CH, 7'h00};
      min_q       <= 8'h00;
      hour_q      <= 8'h00;
      date_q      <= 8'h01;
      month_q     <= 8'h01;
      week_q      <= 8'h01;
      year_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      ce_sync_q   <= ce_sync_d;
      sclk_sync_q <= sclk_sync_d;
      io_sync_q   <= io_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      oe_q        <= oe_d;
      pend_q      <= pend_d;
      wp_q        <= wp_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      date_q      <= date_d;
      month_q     <= month_d;
      week_q      <= week_d;
      year_q      <= year_d;
    end
  end

endmodule
